// File: rtl/scratchpad_bank_ctrl.sv
// scratchpad_bank_ctrl
//   Request-side controller in front of one scratchpad SRAM bank. Requests are buffered in a
//   small FIFO and issued to the bank in strict program order, at most one per cycle. Read data
//   is returned in order through a response FIFO. Read credits bound the reads in flight plus
//   the buffered responses, so bank read data always has a slot to land in.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_*                request valid/ready handshake (wen=1 write, wen=0 read)
//   rsp_*                read response valid/ready handshake
//   bank_*               bank control port (single-cycle ren/wen strobes) and read return
//   err_o                sticky protocol error (only when SCRATCHPAD_CTRL_ERRCHK_EN is defined)
//
// Configuration
//   SCRATCHPAD_CTRL_ERRCHK_EN  adds err_o: set on bank_rvalid_i with no read in flight, or on a
//                              push into a full response FIFO (that data is dropped).
module scratchpad_bank_ctrl #(
  parameter int unsigned ADDRBITS   = 9,
  parameter int unsigned REQ_DEPTH  = 4,
  parameter int unsigned RD_CREDITS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDRBITS-1:0] req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic [ADDRBITS-1:0] bank_addr_o,
  output logic                bank_ren_o,
  output logic                bank_wen_o,
  output logic [31:0]         bank_wdata_o,
  input  logic [31:0]         bank_rdata_i,
  input  logic                bank_rvalid_i
`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
  ,
  output logic                err_o
`endif
);

  localparam int unsigned ReqPtrW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned ReqCntW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned CredW   = $clog2(RD_CREDITS + 1);
  localparam int unsigned RspPtrW = (RD_CREDITS > 1) ? $clog2(RD_CREDITS) : 1;
  localparam logic [RspPtrW-1:0] RspLast = RspPtrW'(RD_CREDITS - 1);

  // Request FIFO storage (power-of-two depth, pointers wrap naturally)
  logic                req_wen_q   [REQ_DEPTH];
  logic [ADDRBITS-1:0] req_addr_q  [REQ_DEPTH];
  logic [31:0]         req_wdata_q [REQ_DEPTH];
  logic [ReqPtrW-1:0]  req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
  logic [ReqCntW-1:0]  req_cnt_q, req_cnt_d;
  logic                req_ready_q, req_ready_d;

  // Response FIFO storage (RD_CREDITS entries, explicit wrap)
  logic [31:0]         rsp_data_q [RD_CREDITS];
  logic [RspPtrW-1:0]  rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [CredW-1:0]    rsp_cnt_q, rsp_cnt_d;

  logic [CredW-1:0]    credits_q, credits_d;
  logic [CredW-1:0]    inflight_q, inflight_d;

  logic                req_push, head_valid, head_wen, issue, rd_issue;
  logic                rsp_pop, rsp_full, rvalid_ok, rsp_push;
  logic [ADDRBITS-1:0] head_addr;
  logic [31:0]         head_wdata;

  assign req_push   = req_valid_i && req_ready_q;
  assign head_valid = (req_cnt_q != '0);
  assign head_wen   = req_wen_q[req_rptr_q];
  assign head_addr  = req_addr_q[req_rptr_q];
  assign head_wdata = req_wdata_q[req_rptr_q];

  // A read at the head waits for a credit and blocks everything behind it.
  assign issue    = head_valid && (head_wen || (credits_q < CredW'(RD_CREDITS)));
  assign rd_issue = issue && !head_wen;

  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  assign rsp_full    = (rsp_cnt_q == CredW'(RD_CREDITS));
  // rvalid with nothing outstanding (e.g. a read discarded by reset) is ignored.
  assign rvalid_ok   = bank_rvalid_i && (inflight_q != '0);
  assign rsp_push    = rvalid_ok && !rsp_full;

  always_comb begin
    req_wptr_d = req_push ? req_wptr_q + 1'b1 : req_wptr_q;
    req_rptr_d = issue ? req_rptr_q + 1'b1 : req_rptr_q;
    req_cnt_d  = req_cnt_q;
    unique case ({req_push, issue})
      2'b10:   req_cnt_d = req_cnt_q + 1'b1;
      2'b01:   req_cnt_d = req_cnt_q - 1'b1;
      default: req_cnt_d = req_cnt_q;
    endcase
    // Registered ready: a pop at full frees the slot only from the next cycle.
    req_ready_d = (req_cnt_d != ReqCntW'(REQ_DEPTH));

    credits_d = credits_q;
    unique case ({rd_issue, rsp_pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase

    inflight_d = inflight_q;
    unique case ({rd_issue, rvalid_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    rsp_wptr_d = rsp_wptr_q;
    if (rsp_push) rsp_wptr_d = (rsp_wptr_q == RspLast) ? '0 : rsp_wptr_q + 1'b1;
    rsp_rptr_d = rsp_rptr_q;
    if (rsp_pop) rsp_rptr_d = (rsp_rptr_q == RspLast) ? '0 : rsp_rptr_q + 1'b1;
    rsp_cnt_d = rsp_cnt_q;
    unique case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
      2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
      default: rsp_cnt_d = rsp_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_wptr_q  <= '0;
      req_rptr_q  <= '0;
      req_cnt_q   <= '0;
      req_ready_q <= 1'b0;
      rsp_wptr_q  <= '0;
      rsp_rptr_q  <= '0;
      rsp_cnt_q   <= '0;
      credits_q   <= '0;
      inflight_q  <= '0;
    end else begin
      req_wptr_q  <= req_wptr_d;
      req_rptr_q  <= req_rptr_d;
      req_cnt_q   <= req_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_wptr_q  <= rsp_wptr_d;
      rsp_rptr_q  <= rsp_rptr_d;
      rsp_cnt_q   <= rsp_cnt_d;
      credits_q   <= credits_d;
      inflight_q  <= inflight_d;
    end
  end

  // Payload storage needs no reset: occupancy counters gate every use.
  always_ff @(posedge clk_i) begin
    if (req_push) begin
      req_wen_q[req_wptr_q]   <= req_wen_i;
      req_addr_q[req_wptr_q]  <= req_addr_i;
      req_wdata_q[req_wptr_q] <= req_wdata_i;
    end
    if (rsp_push) rsp_data_q[rsp_wptr_q] <= bank_rdata_i;
  end

  assign req_ready_o  = req_ready_q;
  assign bank_ren_o   = rd_issue;
  assign bank_wen_o   = issue && head_wen;
  assign bank_addr_o  = issue ? head_addr : '0;
  assign bank_wdata_o = (issue && head_wen) ? head_wdata : '0;
  assign rsp_rdata_o  = rsp_valid_o ? rsp_data_q[rsp_rptr_q] : '0;

`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
  logic err_q, err_d;

  assign err_d = err_q || (bank_rvalid_i && (inflight_q == '0)) || (rvalid_ok && rsp_full);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_scratchpad_bank_ctrl.sv
module tb_scratchpad_bank_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CRED  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] bank_addr;
  logic          bank_ren, bank_wen;
  logic [31:0]   bank_wdata, bank_rdata;
  logic          bank_rvalid;
`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  scratchpad_bank_ctrl #(
    .ADDRBITS  (AW),
    .REQ_DEPTH (DEPTH),
    .RD_CREDITS(CRED)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wen_i   (req_wen),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .bank_addr_o (bank_addr),
    .bank_ren_o  (bank_ren),
    .bank_wen_o  (bank_wen),
    .bank_wdata_o(bank_wdata),
    .bank_rdata_i(bank_rdata),
    .bank_rvalid_i(bank_rvalid)
`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
    ,
    .err_o       (err)
`endif
  );

  typedef struct {logic wen; logic [AW-1:0] addr; logic [31:0] wdata; int acc;} strobe_t;
  typedef struct {logic [31:0] data; int acc;} rsp_t;

  strobe_t     strobe_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] shadow[512];
  logic [31:0] bank_mem[512];
  logic        pipe_v[4];
  logic [31:0] pipe_d[4];

  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          n_wen = 0, n_ren = 0, n_rsp = 0;
  int          bank_lat = 1;
  bit          chk_lat = 0, watch_ready = 0, ready_drop = 0, no_rsp = 0, spur = 0;
  bit          hold_prev = 0;
  logic [31:0] prev_data, last_rsp_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'hA5A50000 ^ (a * 32'h1001);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: data returns bank_lat cycles after the strobe is sampled.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe_v[i] <= pipe_v[i+1];
      pipe_d[i] <= pipe_d[i+1];
    end
    pipe_v[3] <= 1'b0;
    if (bank_ren) begin
      pipe_v[bank_lat-1] <= 1'b1;
      pipe_d[bank_lat-1] <= bank_mem[bank_addr];
    end
    if (bank_wen) bank_mem[bank_addr] <= bank_wdata;
  end

  assign bank_rvalid = pipe_v[0] | spur;
  assign bank_rdata  = pipe_d[0];

  // Monitors and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    strobe_t s;
    rsp_t    r;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (bank_ren || bank_wen) begin
        check_eq("strobe_onehot", {63'd0, bank_ren & bank_wen}, 64'd0);
        if (strobe_q.size() == 0) begin
          check_eq("strobe_unexpected", {62'd0, bank_ren, bank_wen}, 64'd0);
        end else begin
          s = strobe_q.pop_front();
          check_eq("strobe_wen", {63'd0, bank_wen}, {63'd0, s.wen});
          check_eq("strobe_addr", {55'd0, bank_addr}, {55'd0, s.addr});
          check_eq("strobe_wdata", {32'd0, bank_wdata}, {32'd0, s.wdata});
          if (chk_lat) check_eq("strobe_lat", 64'(cyc - s.acc), 64'd1);
        end
        if (bank_wen) n_wen++;
        if (bank_ren) n_ren++;
      end
      if (hold_prev) begin
        check_eq("rsp_hold_valid", {63'd0, rsp_valid}, 64'd1);
        check_eq("rsp_hold_data", {32'd0, rsp_rdata}, {32'd0, prev_data});
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_data = rsp_rdata;
      if (no_rsp) check_eq("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        last_rsp_data = rsp_rdata;
        if (rsp_q.size() == 0) begin
          check_eq("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check_eq("rsp_data", {32'd0, rsp_rdata}, {32'd0, r.data});
          if (chk_lat) check_eq("rsp_lat", 64'(cyc - r.acc), 64'd3);
        end
      end
      if (req_valid && req_ready) begin
        s.wen   = req_wen;
        s.addr  = req_addr;
        s.wdata = req_wen ? req_wdata : 32'd0;
        s.acc   = cyc;
        strobe_q.push_back(s);
        if (req_wen) begin
          shadow[req_addr] = req_wdata;
        end else begin
          r.data = shadow[req_addr];
          r.acc  = cyc;
          rsp_q.push_back(r);
        end
      end
      if (watch_ready && !req_ready) ready_drop = 1;
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    bit ok = 0;
    req_valid = 1'b1;
    req_wen   = w;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("send_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, {63'd0, req_ready}, 64'd0);
    check_eq({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check_eq({tag, "_rsp_rdata"}, {32'd0, rsp_rdata}, 64'd0);
    check_eq({tag, "_ren"}, {63'd0, bank_ren}, 64'd0);
    check_eq({tag, "_wen"}, {63'd0, bank_wen}, 64'd0);
    check_eq({tag, "_addr"}, {55'd0, bank_addr}, 64'd0);
    check_eq({tag, "_wdata"}, {32'd0, bank_wdata}, 64'd0);
`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
    check_eq({tag, "_err"}, {63'd0, err}, 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_wen, b_ren, b_rsp, rel;
    for (int i = 0; i < 512; i++) begin
      shadow[i]   = init_val(i);
      bank_mem[i] = init_val(i);
    end
    for (int i = 0; i < 4; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 32'd0;
    end
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_after", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;

    // Write then read back, 1-cycle bank, minimum latencies
    chk_lat = 1; rsp_ready = 1;
    b_wen = n_wen; b_ren = n_ren; b_rsp = n_rsp;
    send(1'b1, 9'h005, 32'hDEADBEEF);
    send(1'b0, 9'h005, 32'h0);
    req_valid = 0;
    repeat (10) @(negedge clk);
    check_eq("t1_nwen", 64'(n_wen - b_wen), 64'd1);
    check_eq("t1_nren", 64'(n_ren - b_ren), 64'd1);
    check_eq("t1_nrsp", 64'(n_rsp - b_rsp), 64'd1);
    check_eq("t1_rdata", {32'd0, last_rsp_data}, 64'hDEADBEEF);

    // Six back-to-back writes: one strobe per cycle, ready never drops
    @(posedge clk); #1;
    b_wen = n_wen; ready_drop = 0; watch_ready = 1;
    for (int i = 0; i < 6; i++) send(1'b1, AW'(9'h010 + i), 32'h11111111 * (i + 1));
    req_valid = 0; watch_ready = 0;
    repeat (4) @(negedge clk);
    check_eq("t2_nwen", 64'(n_wen - b_wen), 64'd6);
    check_eq("t2_ready_drop", {63'd0, ready_drop}, 64'd0);

    // Four reads with rsp_ready low: credits stall after two
    chk_lat = 0; rsp_ready = 0;
    @(posedge clk); #1;
    b_ren = n_ren; b_rsp = n_rsp;
    for (int a = 1; a <= 4; a++) send(1'b0, AW'(a), 32'h0);
    req_valid = 0;
    repeat (10) @(negedge clk);
    check_eq("t3_nren_stall", 64'(n_ren - b_ren), 64'd2);
    check_eq("t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check_eq("t3_head", {32'd0, rsp_rdata}, {32'd0, init_val(1)});
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    rel = cyc;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bank_ren) break;
    end
    check_eq("t3_stall_lat", 64'(cyc - rel), 64'd1);
    repeat (20) @(negedge clk);
    check_eq("t3_nrsp", 64'(n_rsp - b_rsp), 64'd4);
    check_eq("t3_nren", 64'(n_ren - b_ren), 64'd4);
    check_eq("t3_sb_empty", 64'(rsp_q.size()), 64'd0);

    // Credit stall holds the head; FIFO fills and back-pressures
    @(posedge clk); #1;
    rsp_ready = 0;
    b_rsp = n_rsp;
    send(1'b0, 9'h020, 32'h0);
    send(1'b0, 9'h021, 32'h0);
    req_valid = 0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    b_wen = n_wen; b_ren = n_ren;
    send(1'b0, 9'h022, 32'h0);
    send(1'b1, 9'h023, 32'hCAFE0001);
    send(1'b1, 9'h024, 32'hCAFE0002);
    send(1'b0, 9'h023, 32'h0);
    req_valid = 1; req_wen = 1; req_addr = 9'h025; req_wdata = 32'hCAFE0003;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check_eq("t4_full", {63'd0, req_ready}, 64'd0);
    end
    check_eq("t4_blocked_wen", 64'(n_wen - b_wen), 64'd0);
    check_eq("t4_blocked_ren", 64'(n_ren - b_ren), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1;
    send(1'b1, 9'h025, 32'hCAFE0003);
    send(1'b0, 9'h025, 32'h0);
    req_valid = 0;
    repeat (30) @(negedge clk);
    check_eq("t4_nrsp", 64'(n_rsp - b_rsp), 64'd5);
    check_eq("t4_sb_empty", 64'(rsp_q.size()), 64'd0);
    check_eq("t4_strobe_empty", 64'(strobe_q.size()), 64'd0);
`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
    check_eq("t4_no_err", {63'd0, err}, 64'd0);
`endif

    // Reset with two reads in flight on a 3-cycle bank
    @(posedge clk); #1;
    bank_lat = 3;
    b_ren = n_ren;
    send(1'b0, 9'h030, 32'h0);
    send(1'b0, 9'h031, 32'h0);
    req_valid = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    strobe_q.delete();
    rsp_q.delete();
    check_eq("t5_inflight", 64'(n_ren - b_ren), 64'd2);
    @(negedge clk);
    check_idle_outputs("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    no_rsp = 1;
    repeat (8) @(negedge clk);
    no_rsp = 0;
    check_eq("t5_ready", {63'd0, req_ready}, 64'd1);
    bank_lat = 1;

`ifdef SCRATCHPAD_CTRL_ERRCHK_EN
    // Spurious rvalid while idle sets a sticky error
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_err_clear", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    spur = 1;
    @(posedge clk); #1;
    spur = 0;
    @(negedge clk);
    check_eq("t6_err_set", {63'd0, err}, 64'd1);
    repeat (5) @(negedge clk);
    check_eq("t6_err_sticky", {63'd0, err}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_err_rst", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scratchpad_bank_ctrl.md
# scratchpad_bank_ctrl

Request-side controller that sits directly upstream of one scratchpad SRAM bank. It accepts read/write requests from a requester over a valid/ready handshake and buffers them in a small request FIFO. It issues them to the bank's control port at most one per cycle and returns read data, in order, through a response valid/ready handshake. Read credits bound outstanding reads so that no bank read data is ever dropped.

## Interface
- ADDRBITS, 9, bank word-address width (512 x 32-bit words = 2 KiB)
- REQ_DEPTH, 4, request FIFO entries (power of two, >= 2)
- RD_CREDITS, 2, max reads in flight plus reads buffered in the response FIFO; response FIFO has RD_CREDITS entries

- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request FIFO not full
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  ADDRBITS  word address
- req_wdata  in  32  write data (ignored for reads)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes read data
- rsp_rdata  out  32  read data
- bank_addr  out  ADDRBITS  to bank addr
- bank_ren  out  1  to bank ren
- bank_wen  out  1  to bank wen
- bank_wdata  out  32  to bank wdata
- bank_rdata  in  32  from bank rdata
- bank_rvalid  in  1  from bank rvalid
- err  out  1  sticky protocol error (present only with SCRATCHPAD_CTRL_ERRCHK_EN)

## Operation
- Accept: req_valid && req_ready pushes {wen, addr, wdata} into the request FIFO.
- Issue: when the FIFO is non-empty, pop the head on the same cycle it is presented to the bank:
  - A write issues unconditionally.
  - A read issues only when credits_used < RD_CREDITS.
- Head blocking: a read blocked by credits blocks everything behind it. Strict program order; no reordering.
- Bank strobes: bank_ren and bank_wen are single-cycle pulses, one per issued request, never both high. bank_addr and bank_wdata are valid only while a strobe is high. bank_wdata is 0 for reads.
- Credits:
  - credits_used = reads in flight + response FIFO occupancy.
  - Increments on a read issue; decrements on a response pop (rsp_valid && rsp_ready).
  - Width is clog2(RD_CREDITS+1). Simultaneous increment and decrement leaves it unchanged.
- Bank read data: the bank returns rvalid in issue order, after 1 or more cycles, one rdata per rvalid. On bank_rvalid, bank_rdata is pushed into the response FIFO. Credits guarantee space.
- Responses:
  - rsp_valid = response FIFO non-empty; rsp_rdata = FIFO head.
  - Once asserted, rsp_valid and rsp_rdata stay stable until rsp_ready.
  - Writes produce no response.
- Reset values: req_ready=0 while nRST is low, 1 from the first cycle after deassertion. rsp_valid=0, rsp_rdata=0, bank_ren=0, bank_wen=0, bank_addr=0, bank_wdata=0, err=0. All FIFOs and counters are cleared.
- Reset mid-operation: queued and in-flight requests are discarded. A bank_rvalid arriving after reset with no read outstanding is ignored (data not pushed).

## Timing
- req_ready is registered: it reflects FIFO fullness as of the previous edge. A pop at full does not free a slot for a push in the same cycle.
- Request to bank: a request accepted at edge N produces its bank strobe in cycle N+1 at the earliest (bank_* driven combinationally from the registered FIFO head). One request per cycle sustained for back-to-back writes.
- Bank to response: bank_rvalid sampled at edge M gives rsp_valid high in cycle M+1. With an empty response FIFO and rsp_ready=1, that is one entry per cycle.
- Minimum read round trip is accept at N, ren in N+1, rvalid at N+2 (1-cycle bank), rsp_valid in N+3.
- Full: REQ_DEPTH accepted without issue leads to req_ready=0 the next cycle.
- Empty: no strobes are driven.
- Credit stall: with RD_CREDITS reads unretired, a head read waits. It issues the cycle after the response pop that frees a credit.

## Configuration
- SCRATCHPAD_CTRL_ERRCHK_EN defined:
  - The err port exists.
  - err is set (sticky until nRST) when bank_rvalid is seen with zero reads in flight, or when a push hits a full response FIFO.
  - In the full-FIFO case the offending data is dropped.
- Undefined: the err port and checking logic are absent; behaviour is otherwise identical.

## Test plan
- Write 0xDEADBEEF to addr 0x005, then read 0x005, with a 1-cycle bank model:
  - bank_wen pulse in the cycle after accept.
  - bank_ren one cycle later.
  - rsp_rdata=0xDEADBEEF with rsp_valid exactly once.
- 6 back-to-back writes, REQ_DEPTH=4, bank strobes every cycle: req_ready never drops, and 6 wen pulses occur with in-order addresses.
- 4 reads (addrs 1..4) with rsp_ready=0 and RD_CREDITS=2:
  - Exactly 2 ren pulses, then stall.
  - Release rsp_ready: data returns in order 1,2,3,4, and no response is lost.
- Hold off issue with rsp_ready=0 and a full credit stall, then push 4 more requests: req_ready=0 after the 4th; the 5th is held until a slot frees.
- Assert nRST mid-burst with 2 reads in flight: all outputs return to 0, a late bank_rvalid is ignored, and rsp_valid stays 0.
- With SCRATCHPAD_CTRL_ERRCHK_EN, a spurious bank_rvalid while idle gives err=1 the next cycle, which holds until reset.
